tt_sweep_ctrl: RTL and testbench

- Sequencer that drives a small N-input combinational logic unit through all 2^N input vectors and samples its single output.
- Builds the observed truth table, compares it against an expected table, and reports a pass/fail summary.
- Sits beside each lab logic block as its on-chip exerciser/self-checker, with a start/busy/done handshake toward the host.

---
 rtl/tt_sweep_ctrl_if.sv | 29 ++
 rtl/tt_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/tt_sweep_ctrl_if.sv
// Host / logic-unit side signals of the truth-table sweep controller.
// The master side is the host plus the unit under control; the slave side is the controller.
interface tt_sweep_ctrl_if #(
  parameter int N_IN = 4
);
  localparam int DEPTH = 1 << N_IN;

  logic             start;
  logic             abort;
  logic [DEPTH-1:0] expected;
  logic             dut_y;
  logic [N_IN-1:0]  dut_in;
  logic             busy;
  logic             done;
  logic [DEPTH-1:0] table_out;
  logic [N_IN:0]    err_cnt;
  logic [N_IN-1:0]  fail_idx;
  logic             pass;

  modport master (
    output start, abort, expected, dut_y,
    input  dut_in, busy, done, table_out, err_cnt, fail_idx, pass
  );

  modport slave (
    input  start, abort, expected, dut_y,
    output dut_in, busy, done, table_out, err_cnt, fail_idx, pass
  );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Sweeps an N_IN-input logic unit through every input vector, captures its truth table and
// compares it with an expected table. Define TT_SWEEP_STOP_ON_ERR_EN to end the sweep at the first mismatch.
module tt_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input logic            clk,
  input logic            rst_n,
  tt_sweep_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << N_IN;
  localparam logic [3:0] SETTLE_RLD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  state_t           state;
  logic [DEPTH-1:0] exp_q;
  logic [N_IN-1:0]  idx;
  logic [3:0]       settle_cnt;
  logic [N_IN-1:0]  dut_in_q;
  logic             busy_q;
  logic             done_q;
  logic [DEPTH-1:0] table_q;
  logic [N_IN:0]    err_q;
  logic [N_IN-1:0]  fail_q;
  logic             pass_q;

  logic mismatch;
  logic finish;

  assign mismatch = (bus.dut_y != exp_q[idx]);

`ifdef TT_SWEEP_STOP_ON_ERR_EN
  assign finish = mismatch || (idx == '1);
`else
  assign finish = (idx == '1);
`endif

  // NOTE: all state below uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      exp_q      <= '0;
      idx        <= '0;
      settle_cnt <= '0;
      dut_in_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      table_q    <= '0;
      err_q      <= '0;
      fail_q     <= '0;
      pass_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            exp_q      <= bus.expected;
            table_q    <= '0;
            err_q      <= '0;
            fail_q     <= '0;
            pass_q     <= 1'b0;
            idx        <= '0;
            dut_in_q   <= '0;
            settle_cnt <= SETTLE_RLD;
            busy_q     <= 1'b1;
            state      <= WAIT;
          end
        end

        WAIT: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            pass_q <= 1'b0;
            state  <= IDLE;
          end else if (settle_cnt == '0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        SAMPLE: begin
          // Abort wins over sampling, so the aborted vector leaves no trace in the results.
          if (bus.abort) begin
            busy_q <= 1'b0;
            pass_q <= 1'b0;
            state  <= IDLE;
          end else begin
            table_q[idx] <= bus.dut_y;
            if (mismatch) begin
              err_q <= err_q + 1'b1;
              if (err_q == '0) fail_q <= idx;
            end
            if (finish) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              idx        <= idx + 1'b1;
              dut_in_q   <= idx + 1'b1;
              settle_cnt <= SETTLE_RLD;
              state      <= WAIT;
            end
          end
        end

        DONE: begin
          pass_q <= (err_q == '0);
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_out = table_q;
  assign bus.err_cnt   = err_q;
  assign bus.fail_idx  = fail_q;
  assign bus.pass      = pass_q;
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: table-driven vectors, hand sequences for handshake corners and
// randomized truth tables checked against a vector-by-vector reference model.
module tb_tt_sweep_ctrl;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] func0;
  logic [15:0] func1;

  tt_sweep_ctrl_if #(.N_IN(4)) bus0 ();
  tt_sweep_ctrl_if #(.N_IN(4)) bus1 ();

  // The logic unit under control is a lookup of the current input vector.
  assign bus0.dut_y = func0[bus0.dut_in];
  assign bus1.dut_y = func1[bus1.dut_in];

  tt_sweep_ctrl #(.N_IN(4), .SETTLE(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  tt_sweep_ctrl #(.N_IN(4), .SETTLE(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the vectors in order, stopping at the first mismatch when that option is built in.
  task automatic model(input logic [15:0] e, input logic [15:0] f, input int settle,
                       output logic [15:0] tbl, output int err, output int fidx,
                       output bit pas, output int dedge);
    tbl = '0; err = 0; fidx = 0; pas = 1'b1; dedge = 16 * (settle + 1);
    for (int v = 0; v < 16; v++) begin
      tbl[v] = f[v];
      if (f[v] != e[v]) begin
        if (err == 0) fidx = v;
        err++;
`ifdef TT_SWEEP_STOP_ON_ERR_EN
        dedge = (v + 1) * (settle + 1);
        break;
`endif
      end
    end
    pas = (err == 0);
  endtask

  // Runs one sweep on the SETTLE=1 instance; optional start re-pulses and an abort edge.
  task automatic sweep(input logic [15:0] exp_v, input logic [15:0] fn,
                       input int ra, input int rb, input int ab,
                       output int done_edge, output int done_pulses);
    bus0.expected = exp_v;
    func0 = fn;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    done_edge = -1;
    done_pulses = 0;
    for (int k = 1; k <= 80; k++) begin
      bus0.start = (k == ra) || (k == rb);
      bus0.abort = (k == ab);
      tick();
      bus0.start = 1'b0;
      bus0.abort = 1'b0;
      if (bus0.done) begin
        done_pulses++;
        if (done_edge < 0) done_edge = k;
      end
      if (ab == k) check("abort_busy", bus0.busy, 1'b0);
      if (ab == 0 && done_edge >= 0 && !bus0.busy) break;
    end
  endtask

  typedef struct {
    logic [15:0] exp_v;
    logic [15:0] fn;
    logic [15:0] tbl;
    int          err;
    int          fidx;
    bit          pas;
    int          dedge;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          de, dp, bad, e_err, e_fidx, e_dedge;
    logic [15:0] e_tbl, r_exp, r_fn, mask;
    bit          e_pas;

    vecs[0] = '{16'h5555, 16'h5555, 16'h5555, 0, 0, 1'b1, 32};
`ifdef TT_SWEEP_STOP_ON_ERR_EN
    vecs[1] = '{16'h5554, 16'h5555, 16'h0001, 1, 0, 1'b0, 2};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'h0001, 1, 0, 1'b0, 2};
    vecs[3] = '{16'h5555, 16'h5455, 16'h0055, 1, 8, 1'b0, 18};
`else
    vecs[1] = '{16'h5554, 16'h5555, 16'h5555, 1, 0, 1'b0, 32};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16, 0, 1'b0, 32};
    vecs[3] = '{16'h5555, 16'h5455, 16'h5455, 1, 8, 1'b0, 32};
`endif
    vecs[4] = '{16'hFFFF, 16'h7FFF, 16'h7FFF, 1, 15, 1'b0, 32};

    rst_n = 1'b0;
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.expected = '0; func0 = 16'h5555;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.expected = '0; func1 = 16'h5555;
    #2;
    check("rst_dut_in", bus0.dut_in, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_done", bus0.done, 0);
    check("rst_table", bus0.table_out, 0);
    check("rst_err", bus0.err_cnt, 0);
    check("rst_fail", bus0.fail_idx, 0);
    check("rst_pass", bus0.pass, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      sweep(vecs[i].exp_v, vecs[i].fn, 0, 0, 0, de, dp);
      check($sformatf("vec%0d_done_edge", i), de, vecs[i].dedge);
      check($sformatf("vec%0d_done_pulses", i), dp, 1);
      check($sformatf("vec%0d_table", i), bus0.table_out, vecs[i].tbl);
      check($sformatf("vec%0d_err", i), bus0.err_cnt, vecs[i].err);
      if (vecs[i].err != 0) check($sformatf("vec%0d_fail_idx", i), bus0.fail_idx, vecs[i].fidx);
      check($sformatf("vec%0d_pass", i), bus0.pass, vecs[i].pas);
    end

    // Results hold through idle cycles and an abort while idle.
    bus0.abort = 1'b1;
    tick();
    bus0.abort = 1'b0;
    tick();
    check("idle_abort_table", bus0.table_out, 16'h7FFF);
    check("idle_abort_err", bus0.err_cnt, 1);
    check("idle_abort_fail", bus0.fail_idx, 15);
    check("idle_abort_busy", bus0.busy, 0);

    // Start re-pulses while busy are ignored.
    sweep(16'h5555, 16'h5555, 5, 10, 0, de, dp);
    check("repulse_done_edge", de, 32);
    check("repulse_done_pulses", dp, 1);
    check("repulse_pass", bus0.pass, 1);

    // Abort sampled at edge 10: vectors 0..3 captured, no done.
    sweep(16'h5555, 16'h5555, 0, 0, 10, de, dp);
    check("abort_done_pulses", dp, 0);
    check("abort_pass", bus0.pass, 0);
    check("abort_table", bus0.table_out, 16'h0005);
    check("abort_err", bus0.err_cnt, 0);
    check("abort_busy_after", bus0.busy, 0);

    // Start and abort together in IDLE: start wins.
    bus0.expected = 16'h5555;
    func0 = 16'h5555;
    bus0.start = 1'b1;
    bus0.abort = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    check("start_abort_busy", bus0.busy, 1);
    for (int k = 1; k <= 20; k++) tick();
    // Reset mid-sweep clears everything immediately.
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus0.busy, 0);
    check("midrst_dut_in", bus0.dut_in, 0);
    check("midrst_table", bus0.table_out, 0);
    check("midrst_err", bus0.err_cnt, 0);
    check("midrst_pass", bus0.pass, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("midrst_idle", bus0.busy, 0);

    // Start held high across DONE launches the next sweep right away.
    bus0.start = 1'b1;
    de = -1;
    for (int k = 0; k <= 60 && de < 0; k++) begin
      tick();
      if (bus0.done) de = k;
    end
    check("hold_done_seen", de, 32);
    tick();
    check("hold_busy_drop", bus0.busy, 0);
    tick();
    check("hold_restart", bus0.busy, 1);
    bus0.start = 1'b0;
    for (int k = 0; k <= 60 && bus0.busy; k++) tick();
    check("hold_finish", bus0.busy, 0);

    // SETTLE=3: each vector held 4 cycles, done at edge 64.
    bus1.expected = 16'h5555;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    bad = 0;
    de = -1;
    for (int k = 1; k <= 100 && de < 0; k++) begin
      tick();
      if (bus1.done) de = k;
      else if (bus1.dut_in != 4'(k / 4)) bad++;
    end
    tick();
    check("settle3_hold", bad, 0);
    check("settle3_done_edge", de, 64);
    check("settle3_pass", bus1.pass, 1);
    check("settle3_table", bus1.table_out, 16'h5555);

    // Random truth tables with sparse expected-table corruption.
    for (int i = 0; i < 20; i++) begin
      r_fn = 16'($urandom);
      mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 3) == 0) mask = '0;
      r_exp = r_fn ^ mask;
      model(r_exp, r_fn, 1, e_tbl, e_err, e_fidx, e_pas, e_dedge);
      sweep(r_exp, r_fn, 0, 0, 0, de, dp);
      check($sformatf("rnd%0d_done_edge", i), de, e_dedge);
      check($sformatf("rnd%0d_table", i), bus0.table_out, e_tbl);
      check($sformatf("rnd%0d_err", i), bus0.err_cnt, e_err);
      if (e_err != 0) check($sformatf("rnd%0d_fail_idx", i), bus0.fail_idx, e_fidx);
      check($sformatf("rnd%0d_pass", i), bus0.pass, e_pas);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
